// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (cpu/debug) round-robin arbiter in front of a single-port memory
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_done,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_done,
    output logic [DW-1:0] dbg_rdata,
    input  logic          dbg_lock,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   cpu_stall_cnt
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0] state;
    logic       owner_dbg;
    logic       we_q;
    logic       last_dbg;

    logic arb_state;
    logic cpu_elig;
    logic dbg_elig;
    logic pick_cpu;
    logic pick_dbg;

    // The owner finishing in DONE is excluded so its still-held req is not regranted.
    always_comb begin
        arb_state = 1'b0;
        cpu_elig  = 1'b0;
        dbg_elig  = 1'b0;
        pick_cpu  = 1'b0;
        pick_dbg  = 1'b0;
        arb_state = !reset && (state == IDLE || state == DONE);
        cpu_elig  = arb_state && cpu_req && !dbg_lock && !(state == DONE && !owner_dbg);
        dbg_elig  = arb_state && dbg_req && !(state == DONE && owner_dbg);
        pick_cpu  = cpu_elig && (!dbg_elig || last_dbg);
        pick_dbg  = dbg_elig && !pick_cpu;
    end

    assign cpu_gnt   = pick_cpu;
    assign dbg_gnt   = pick_dbg;
    assign cpu_done  = (state == DONE) && !owner_dbg;
    assign dbg_done  = (state == DONE) && owner_dbg;
    assign mem_read  = (state == ACCESS) && !we_q;
    assign mem_write = (state == ACCESS) && we_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            owner_dbg     <= 1'b0;
            we_q          <= 1'b0;
            last_dbg      <= 1'b1;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            cpu_rdata     <= '0;
            dbg_rdata     <= '0;
            cpu_stall_cnt <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (pick_cpu || pick_dbg) begin
                        state     <= ACCESS;
                        owner_dbg <= pick_dbg;
                        last_dbg  <= pick_dbg;
                        we_q      <= pick_dbg ? dbg_we    : cpu_we;
                        mem_addr  <= pick_dbg ? dbg_addr  : cpu_addr;
                        mem_wdata <= pick_dbg ? dbg_wdata : cpu_wdata;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    state <= DONE;
                    if (!we_q) begin
                        if (owner_dbg) dbg_rdata <= mem_rdata;
                        else           cpu_rdata <= mem_rdata;
                    end
                end
                default: state <= IDLE;
            endcase

            if (cpu_req && !cpu_done && cpu_stall_cnt != 16'hFFFF)
                cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic        cpu_gnt, cpu_done, dbg_gnt, dbg_done;
    logic [31:0] cpu_rdata, dbg_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [15:0] cpu_stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory model: fixed words at 0x10 / 0x20 plus one writable word.
    logic        wr_valid = 1'b0;
    logic [31:0] wr_addr  = 32'h0;
    logic [31:0] wr_data  = 32'h0;

    always @(posedge clk) begin
        if (mem_write) begin
            wr_valid <= 1'b1;
            wr_addr  <= mem_addr;
            wr_data  <= mem_wdata;
        end
    end

    assign mem_rdata = (wr_valid && mem_addr == wr_addr) ? wr_data :
                       (mem_addr == 32'h10) ? 32'h12345678 :
                       (mem_addr == 32'h20) ? 32'hA5A5A5A5 : 32'h0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_done(dbg_done), .dbg_rdata(dbg_rdata),
        .dbg_lock(dbg_lock),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cpu_stall_cnt(cpu_stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; dbg_lock = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_wdata = 32'h0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 32'h0; dbg_wdata = 32'h0;
        tick();
        tick();
        @(negedge clk);
        n_checks++; if (cpu_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_gnt got %b exp 0", cpu_gnt); end
        n_checks++; if ({cpu_done, dbg_done, dbg_gnt} !== 3'b000) begin n_fail++; $display("FAIL rst_done_gnt got %b exp 000", {cpu_done, dbg_done, dbg_gnt}); end
        n_checks++; if ({mem_read, mem_write} !== 2'b00) begin n_fail++; $display("FAIL rst_strobes got %b exp 00", {mem_read, mem_write}); end
        n_checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_mem_regs got %h/%h exp 0/0", mem_addr, mem_wdata); end
        n_checks++; if (cpu_rdata !== 32'h0 || dbg_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h/%h exp 0/0", cpu_rdata, dbg_rdata); end
        n_checks++; if (cpu_stall_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_stall got %h exp 0", cpu_stall_cnt); end
    endtask

    // cpu_req held across reset release: grant on the very first cycle.
    task automatic test_cpu_read();
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (cpu_gnt !== 1'b1) begin n_fail++; $display("FAIL rd_gnt got %b exp 1", cpu_gnt); end
        n_checks++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL rd_early_strobe got %b exp 0", mem_read); end
        tick();
        @(negedge clk);
        n_checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin n_fail++; $display("FAIL rd_strobe got r%b w%b exp r1 w0", mem_read, mem_write); end
        n_checks++; if (mem_addr !== 32'h10) begin n_fail++; $display("FAIL rd_addr got %h exp 00000010", mem_addr); end
        n_checks++; if (cpu_gnt !== 1'b0) begin n_fail++; $display("FAIL rd_gnt_pulse got %b exp 0", cpu_gnt); end
        tick();
        @(negedge clk);
        n_checks++; if (cpu_done !== 1'b1 || dbg_done !== 1'b0) begin n_fail++; $display("FAIL rd_done got c%b d%b exp c1 d0", cpu_done, dbg_done); end
        n_checks++; if (cpu_rdata !== 32'h12345678) begin n_fail++; $display("FAIL rd_data got %h exp 12345678", cpu_rdata); end
        n_checks++; if (cpu_gnt !== 1'b0) begin n_fail++; $display("FAIL rd_no_regrant got %b exp 0", cpu_gnt); end
        n_checks++; if (cpu_stall_cnt !== 16'd2) begin n_fail++; $display("FAIL rd_stall got %0d exp 2", cpu_stall_cnt); end
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        n_checks++; if (cpu_done !== 1'b0 || mem_read !== 1'b0) begin n_fail++; $display("FAIL rd_idle got done%b rd%b exp 0 0", cpu_done, mem_read); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [6:0] exp_cg, exp_dg, exp_cd, exp_dd;
        exp_cg = 7'b0010001;  // bit c = cycle c
        exp_dg = 7'b1000100;
        exp_cd = 7'b1000100;
        exp_dd = 7'b0010000;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h20;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            if (c > 0) tick();
            @(negedge clk);
            n_checks++; if (cpu_gnt !== exp_cg[c] || dbg_gnt !== exp_dg[c]) begin n_fail++; $display("FAIL rr_gnt cyc%0d got c%b d%b exp c%b d%b", c, cpu_gnt, dbg_gnt, exp_cg[c], exp_dg[c]); end
            n_checks++; if (cpu_done !== exp_cd[c] || dbg_done !== exp_dd[c]) begin n_fail++; $display("FAIL rr_done cyc%0d got c%b d%b exp c%b d%b", c, cpu_done, dbg_done, exp_cd[c], exp_dd[c]); end
            n_checks++; if (mem_read && mem_write) begin n_fail++; $display("FAIL rr_excl cyc%0d got both strobes high exp at most one", c); end
            if (c == 4) begin
                n_checks++; if (dbg_rdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL rr_dbg_rdata got %h exp a5a5a5a5", dbg_rdata); end
            end
        end
        // Drop both after dbg's grant: the latched access must still run.
        tick();
        cpu_req = 1'b0; dbg_req = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h20) begin n_fail++; $display("FAIL rr_drop_access got rd%b addr %h exp rd1 addr 00000020", mem_read, mem_addr); end
        tick();
        @(negedge clk);
        n_checks++; if (dbg_done !== 1'b1) begin n_fail++; $display("FAIL rr_drop_done got %b exp 1", dbg_done); end
        tick();
    endtask

    task automatic test_dbg_lock();
        logic [5:0] exp_dg;
        exp_dg = 6'b001001;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h20;
        dbg_lock = 1'b1;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            if (c > 0) tick();
            @(negedge clk);
            n_checks++; if (cpu_gnt !== 1'b0 || dbg_gnt !== exp_dg[c]) begin n_fail++; $display("FAIL lock_gnt cyc%0d got c%b d%b exp c0 d%b", c, cpu_gnt, dbg_gnt, exp_dg[c]); end
            n_checks++; if (cpu_stall_cnt !== 16'(c)) begin n_fail++; $display("FAIL lock_stall cyc%0d got %0d exp %0d", c, cpu_stall_cnt, c); end
        end
        tick();
        dbg_lock = 1'b0;
        @(negedge clk);
        n_checks++; if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0) begin n_fail++; $display("FAIL unlock_gnt got c%b d%b exp c1 d0", cpu_gnt, dbg_gnt); end
        tick();
        cpu_req = 1'b0; dbg_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_write_then_read();
        int nwr;
        nwr = 0;
        cpu_req = 1'b0; dbg_req = 1'b0; dbg_lock = 1'b0;
        do_reset();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h40; dbg_wdata = 32'hDEADBEEF;
        @(negedge clk);
        nwr += int'(mem_write);
        n_checks++; if (dbg_gnt !== 1'b1) begin n_fail++; $display("FAIL wr_gnt got %b exp 1", dbg_gnt); end
        tick();
        @(negedge clk);
        nwr += int'(mem_write);
        n_checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin n_fail++; $display("FAIL wr_strobe got w%b r%b exp w1 r0", mem_write, mem_read); end
        n_checks++; if (mem_addr !== 32'h40 || mem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_bus got %h/%h exp 00000040/deadbeef", mem_addr, mem_wdata); end
        tick();
        dbg_req = 1'b0;
        @(negedge clk);
        nwr += int'(mem_write);
        n_checks++; if (dbg_done !== 1'b1) begin n_fail++; $display("FAIL wr_done got %b exp 1", dbg_done); end
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
        @(negedge clk);
        nwr += int'(mem_write);
        n_checks++; if (cpu_gnt !== 1'b1) begin n_fail++; $display("FAIL wr_rd_gnt got %b exp 1", cpu_gnt); end
        tick();
        @(negedge clk);
        nwr += int'(mem_write);
        tick();
        @(negedge clk);
        nwr += int'(mem_write);
        n_checks++; if (cpu_done !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_rd_data got done%b %h exp done1 deadbeef", cpu_done, cpu_rdata); end
        n_checks++; if (dbg_rdata !== 32'h0) begin n_fail++; $display("FAIL wr_dbg_rdata got %h exp 0", dbg_rdata); end
        n_checks++; if (nwr !== 1) begin n_fail++; $display("FAIL wr_count got %0d exp 1", nwr); end
        tick();
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_abort();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        dbg_req = 1'b0; dbg_lock = 1'b0;
        do_reset();
        @(negedge clk);
        n_checks++; if (cpu_gnt !== 1'b1) begin n_fail++; $display("FAIL ab_gnt got %b exp 1", cpu_gnt); end
        tick();
        @(negedge clk);
        n_checks++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL ab_access got %b exp 1", mem_read); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (cpu_done !== 1'b0) begin n_fail++; $display("FAIL ab_no_done got %b exp 0", cpu_done); end
        n_checks++; if ({mem_read, mem_write} !== 2'b00) begin n_fail++; $display("FAIL ab_strobes got %b exp 00", {mem_read, mem_write}); end
        n_checks++; if (cpu_stall_cnt !== 16'h0 || cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL ab_regs got %h/%h exp 0/0", cpu_stall_cnt, cpu_rdata); end
        n_checks++; if (cpu_gnt !== 1'b1) begin n_fail++; $display("FAIL ab_regrant got %b exp 1", cpu_gnt); end
        tick();
        tick();
        @(negedge clk);
        n_checks++; if (cpu_done !== 1'b1 || cpu_rdata !== 32'h12345678) begin n_fail++; $display("FAIL ab_retry got done%b %h exp done1 12345678", cpu_done, cpu_rdata); end
        tick();
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_stall_saturate();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        dbg_req = 1'b0; dbg_lock = 1'b1;
        do_reset();
        repeat (65534) tick();
        @(negedge clk);
        n_checks++; if (cpu_stall_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL sat_pre got %h exp fffe", cpu_stall_cnt); end
        tick();
        @(negedge clk);
        n_checks++; if (cpu_stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hit got %h exp ffff", cpu_stall_cnt); end
        repeat (5) tick();
        @(negedge clk);
        n_checks++; if (cpu_stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got %h exp ffff", cpu_stall_cnt); end
        cpu_req = 1'b0; dbg_lock = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_round_robin();
        test_dbg_lock();
        test_write_then_read();
        test_reset_abort();
        test_stall_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters: AW, 32, address width; DW, 32, data width.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 cpu_req  in  1  CPU access request; held with cpu_we/cpu_addr/cpu_wdata stable until cpu_done.
REQ-005 cpu_we  in  1  1 = write, 0 = read.
REQ-006 cpu_addr  in  AW  CPU byte address.
REQ-007 cpu_wdata  in  DW  CPU write data.
REQ-008 cpu_gnt  out  1  one-cycle pulse: CPU request latched.
REQ-009 cpu_done  out  1  one-cycle pulse: CPU access complete; cpu_rdata valid on reads.
REQ-010 cpu_rdata  out  DW  registered read data for the CPU.
REQ-011 dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_done, dbg_rdata: same widths and semantics as the cpu_* ports, for the debug/loader port.
REQ-012 dbg_lock  in  1  while high, arbitration admits only the debug port (CPU held off).
REQ-013 mem_read  out  1  memory read strobe.
REQ-014 mem_write  out  1  memory write strobe, committed on the rising clk at the end of the strobe cycle.
REQ-015 mem_addr  out  AW; mem_wdata  out  DW: registered access address and data.
REQ-016 mem_rdata  in  DW  asynchronous-read data, valid in the same cycle as mem_read.
REQ-017 cpu_stall_cnt  out  16  saturating count of cycles with cpu_req high and not cpu_done.

Function
REQ-018 States SHALL be IDLE, ACCESS and DONE.
REQ-019 Arbitration SHALL be evaluated in IDLE and DONE: a winner latches addr/we/wdata/owner, pulses its gnt that cycle, and next state is ACCESS; with no eligible request, next state is IDLE.
REQ-020 Request eligibility in DONE SHALL exclude the owner of the access completing that cycle; this prevents a held req from being regranted before the requester drops it.
REQ-021 When both ports are eligible, the port not granted most recently SHALL win (round-robin); the last-winner bit SHALL reset to dbg, so the CPU wins the first tie.
REQ-022 While dbg_lock is 1, cpu_req SHALL be ignored by arbitration; an access already in ACCESS/DONE SHALL complete normally.
REQ-023 ACCESS SHALL last exactly one cycle with mem_read = ~we or mem_write = we and mem_addr/mem_wdata from the latched values; on reads, mem_rdata SHALL be registered into the owner's rdata at the end of ACCESS.
REQ-024 DONE SHALL last one cycle and pulse the owner's done; the other port's rdata and done SHALL be unchanged/0.
REQ-025 Latency: req sampled high in IDLE at cycle N gives gnt at N, strobe at N+1 and done at N+2; the minimum period between back-to-back grants of alternating owners SHALL be 2 cycles.
REQ-026 A req that drops before its gnt SHALL be withdrawn with no memory access; a drop after gnt SHALL NOT cancel the latched access.
REQ-027 mem_read and mem_write SHALL never be high simultaneously and SHALL be high only in ACCESS.
REQ-028 cpu_stall_cnt SHALL increment by 1 per qualifying cycle, saturate at 16'hFFFF, and never wrap.

Reset
REQ-029 On reset, next state is IDLE; all gnt/done/mem strobes go to 0, mem_addr/mem_wdata/cpu_rdata/dbg_rdata go to 0, last-winner goes to dbg and cpu_stall_cnt goes to 0, all on that edge.
REQ-030 Reset in ACCESS or DONE SHALL abort the access with no done pulse; a write whose strobe cycle ends on the reset edge is undefined in memory and need not be checked.
REQ-031 Requests held across reset deassertion SHALL be arbitrated normally from IDLE on the first cycle after reset.

Verification
REQ-032 CPU read, addr 0x10, memory word 0x12345678 -> cpu_gnt at N, mem_read with mem_addr 0x10 at N+1, cpu_done with cpu_rdata 0x12345678 at N+2.
REQ-033 Both ports request from IDLE just after reset -> CPU granted first, dbg granted in the CPU's DONE cycle; then with both held, grants alternate cpu, dbg, cpu.
REQ-034 dbg_lock=1 with both requesting -> only dbg granted, cpu_stall_cnt increments every cycle; release lock -> CPU granted at the next arbitration point.
REQ-035 dbg write, addr 0x40, data 0xDEADBEEF, then CPU read of 0x40 -> single mem_write cycle, and CPU read returns 0xDEADBEEF.
REQ-036 Reset asserted during ACCESS of a CPU read -> no cpu_done, strobes 0 next cycle, counter 0, fresh arbitration after reset.
REQ-037 cpu_req held for more than 65535 cycles under dbg_lock -> cpu_stall_cnt holds at 0xFFFF.
